spike_event_processor: RTL and testbench
========================================

# spike_event_processor

Parametrised successor to `processing_system`. It accepts a time-interleaved sample stream covering `NUM_CHANNELS` channels and runs per-channel derivative spike detection with two-level classification and a per-channel refractory timeout. Detected events go into a timestamped event FIFO with a valid/ready drain port. It sits between the sample deserialiser and the event readout logic.

## Interface
- `NUM_CHANNELS`, 4, number of interleaved channels (≥2)
- `SAMPLE_W`, 8, unsigned sample width
- `TIMEOUT_W`, 16, refractory counter width
- `TS_W`, 16, frame timestamp width
- `FIFO_DEPTH`, 8, event FIFO entries (power of two)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `sample_in` in `SAMPLE_W`: current sample
- `sample_valid` in 1: sample accepted this cycle
- `frame_start` in 1: qualifies `sample_valid`; forces this sample to channel 0
- `class_a_thresh_in` in `SAMPLE_W`: class A threshold
- `class_b_thresh_in` in `SAMPLE_W`: class B threshold
- `timeout_period_in` in `TIMEOUT_W`: refractory length, counted in that channel's samples
- `spike_detection_array` out `NUM_CHANNELS`: per-channel spike flag from the latest sample
- `event_out_array` out `2*NUM_CHANNELS`: per-channel class; bits [2c+1:2c] belong to channel c
- `event_valid` out 1: FIFO non-empty
- `event_ready` in 1: consumer pops the head entry
- `event_channel` out `$clog2(NUM_CHANNELS)`: head entry channel
- `event_class` out 2: head entry class
- `event_timestamp` out `TS_W`: head entry frame count
- `fifo_overflow` out 1: sticky flag; set when an event is dropped

## Operation
- Class encoding: 00 none, 01 A, 10 B. 11 is never produced.
- Channel index `ch_idx`:
  - Advances on each `sample_valid` and wraps from `NUM_CHANNELS-1` to 0.
  - `frame_start & sample_valid` processes the sample as channel 0, then sets `ch_idx` to 1.
- Frame counter `ts`:
  - Increments when a channel `NUM_CHANNELS-1` sample is accepted.
  - Wraps modulo 2^`TS_W`.
- Per-channel state: `prev` sample, `prev_valid`, refractory counter `refr`.
- On an accepted sample for channel c:
  - `diff = |sample_in − prev[c]|`, unsigned, `SAMPLE_W` bits.
  - If `prev_valid[c]` is 0, class is 00 and `prev_valid[c]` is set.
  - Else if `refr[c] ≠ 0`, class is 00 and `refr[c]` decrements.
  - Else if `diff ≥ class_b_thresh_in`, class is 10. This check has priority over A even when B < A.
  - Else if `diff ≥ class_a_thresh_in`, class is 01.
  - Else class is 00.
  - Class ≠ 00 loads `refr[c] = timeout_period_in`. A value of 0 means no refractory period.
  - `prev[c] = sample_in` always.
- `spike_detection_array[c] = (class ≠ 00)` and `event_out_array[c]` = class.
  - Both are registered and hold until channel c's next sample.
  - Other channels' bits are unchanged.
- FIFO push: any class ≠ 00 pushes {ts at sample time, c, class}.
- FIFO full:
  - A push while full is dropped and sets `fifo_overflow`, even if a pop happens the same cycle.
  - `fifo_overflow` clears only on reset.
- FIFO pop: `event_valid & event_ready` pops. The FIFO is first-word-fall-through; head fields are valid whenever `event_valid` is high.
- Simultaneous push and pop while not full: both take effect and the occupancy is unchanged.

## Timing
- Sample accepted at edge N:
  - `spike_detection_array`/`event_out_array` update at edge N+1.
  - The FIFO entry is written at edge N+1.
  - `event_valid` rises after edge N+1 if the FIFO was empty.
- Throughput: one sample per cycle, no stall. No backpressure reaches the sample side.
- Thresholds and `timeout_period_in` are sampled on the cycle of use, with no shadowing.
- Reset values:
  - All outputs 0.
  - `ch_idx`, `ts`, `prev`, `prev_valid`, `refr` all 0.
  - FIFO empty, `fifo_overflow` 0.
- Reset asserted mid-frame: all state, including FIFO contents, clears asynchronously. The first sample after release is treated as channel 0 and has no valid predecessor.

## Structure
- Shared package `spike_pkg` holds:
  - Class constants `CLS_NONE`, `CLS_A`, `CLS_B`.
  - The event entry struct {timestamp, channel, class}.
- Sub-module `event_fifo`: synchronous FWFT FIFO parametrised by width and depth, with `full`/`empty`.
- The top level contains the channel indexing, per-channel state arrays and classification.

## Test plan
Configuration for all scenarios: `NUM_CHANNELS`=4, A=20, B=40, timeout=2, `event_ready`=1 unless stated.

- Reset: assert `rst_n`=0 mid-stream → all outputs 0, `event_valid`=0, next sample treated as channel 0.
- Class A: ch0 frames with samples 10 then 35 (diff 25) → after frame 1, `spike_detection_array`=0001, `event_out_array[1:0]`=01, FIFO head {ts=1, ch=0, cls=01}.
- Class B via falling edge: ch2 samples 200 then 150 → `event_out_array[5:4]`=10, FIFO head ch=2, cls=10. Diff of 19 → class 00.
- Refractory:
  - ch1 diffs 50, 60, 60, 60.
  - Results: B, none, none, B.
  - With timeout=0: four B events.
- Overflow and drain:
  - Hold `event_ready`=0 and generate 9 events → 8 stored, 9th dropped, `fifo_overflow`=1.
  - Then `event_ready`=1 → 8 entries drain in order, `event_valid`=0 after, `fifo_overflow` stays 1.
- Wrap and resync:
  - `frame_start` asserted on the third sample of a frame → that sample is channel 0.
  - `ts` at 0xFFFF increments to 0x0000.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared definitions for the spike event processor: class codes and the event FIFO entry layout.
package spike_pkg;

    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_A    = 2'b01;
    localparam logic [1:0] CLS_B    = 2'b10;

    // Entry fields are sized for the widest supported configuration; unused upper bits stay zero.
    localparam int unsigned EVT_TS_MAX_W = 32;
    localparam int unsigned EVT_CH_MAX_W = 8;

    typedef struct packed {
        logic [EVT_TS_MAX_W-1:0] timestamp;
        logic [EVT_CH_MAX_W-1:0] channel;
        logic [1:0]              cls;
    } event_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous first-word-fall-through FIFO; writes while full and reads while empty are ignored.
module event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             wr_en, rd_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_event_processor.sv
// Per-channel derivative spike detector over an interleaved sample stream, with refractory
// timeout and a timestamped event FIFO drained through a valid/ready port.
module spike_event_processor
    import spike_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned SAMPLE_W     = 8,
    parameter int unsigned TIMEOUT_W    = 16,
    parameter int unsigned TS_W         = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [SAMPLE_W-1:0]             sample_in,
    input  logic                            sample_valid,
    input  logic                            frame_start,
    input  logic [SAMPLE_W-1:0]             class_a_thresh_in,
    input  logic [SAMPLE_W-1:0]             class_b_thresh_in,
    input  logic [TIMEOUT_W-1:0]            timeout_period_in,
    output logic [NUM_CHANNELS-1:0]         spike_detection_array,
    output logic [2*NUM_CHANNELS-1:0]       event_out_array,
    output logic                            event_valid,
    input  logic                            event_ready,
    output logic [$clog2(NUM_CHANNELS)-1:0] event_channel,
    output logic [1:0]                      event_class,
    output logic [TS_W-1:0]                 event_timestamp,
    output logic                            fifo_overflow
);

    localparam int unsigned     CH_W    = $clog2(NUM_CHANNELS);
    localparam int unsigned     EVT_W   = $bits(event_t);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

    logic [CH_W-1:0]      ch_q, ch_d, cur_ch;
    logic [TS_W-1:0]      ts_q;
    logic [SAMPLE_W-1:0]  prev_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] prev_valid_q;
    logic [TIMEOUT_W-1:0] refr_q [NUM_CHANNELS];

    logic [SAMPLE_W-1:0]  prev_cur, diff;
    logic [TIMEOUT_W-1:0] refr_cur, refr_d;
    logic [1:0]           cls_d;

    // Classification result of the previous cycle's sample, applied to outputs and FIFO.
    logic                 pend_valid_q;
    logic [CH_W-1:0]      pend_ch_q;
    logic [1:0]           pend_cls_q;
    logic [TS_W-1:0]      pend_ts_q;

    logic [NUM_CHANNELS-1:0]   det_q;
    logic [2*NUM_CHANNELS-1:0] evt_q;
    logic                      overflow_q;

    logic       push, fifo_full, fifo_empty;
    event_t     push_evt, head_evt;
    logic       unused_head;

    always_comb begin
        cur_ch   = frame_start ? '0 : ch_q;
        ch_d     = (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
        prev_cur = prev_q[cur_ch];
        refr_cur = refr_q[cur_ch];
        diff     = (sample_in >= prev_cur) ? sample_in - prev_cur : prev_cur - sample_in;
        cls_d    = CLS_NONE;
        refr_d   = refr_cur;
        if (!prev_valid_q[cur_ch]) begin
            cls_d = CLS_NONE;
        end else if (refr_cur != '0) begin
            refr_d = refr_cur - 1'b1;
        end else if (diff >= class_b_thresh_in) begin
            cls_d  = CLS_B;
            refr_d = timeout_period_in;
        end else if (diff >= class_a_thresh_in) begin
            cls_d  = CLS_A;
            refr_d = timeout_period_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q         <= '0;
            ts_q         <= '0;
            prev_valid_q <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                prev_q[i] <= '0;
                refr_q[i] <= '0;
            end
            pend_valid_q <= 1'b0;
            pend_ch_q    <= '0;
            pend_cls_q   <= CLS_NONE;
            pend_ts_q    <= '0;
        end else begin
            pend_valid_q <= sample_valid;
            if (sample_valid) begin
                ch_q <= ch_d;
                if (cur_ch == LAST_CH) begin
                    ts_q <= ts_q + 1'b1;
                end
                prev_q[cur_ch]       <= sample_in;
                prev_valid_q[cur_ch] <= 1'b1;
                refr_q[cur_ch]       <= refr_d;
                pend_ch_q            <= cur_ch;
                pend_cls_q           <= cls_d;
                pend_ts_q            <= ts_q;
            end
        end
    end

    assign push = pend_valid_q && (pend_cls_q != CLS_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_q      <= '0;
            evt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pend_valid_q) begin
                det_q[pend_ch_q]               <= (pend_cls_q != CLS_NONE);
                evt_q[{pend_ch_q, 1'b0} +: 2] <= pend_cls_q;
            end
            // A dropped event is flagged even if the consumer frees a slot on the same edge.
            if (push && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        push_evt           = '0;
        push_evt.timestamp = EVT_TS_MAX_W'(pend_ts_q);
        push_evt.channel   = EVT_CH_MAX_W'(pend_ch_q);
        push_evt.cls       = pend_cls_q;
    end

    event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_evt),
        .pop   (event_ready),
        .rdata (head_evt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign unused_head           = ^head_evt;
    assign spike_detection_array = det_q;
    assign event_out_array       = evt_q;
    assign event_valid           = !fifo_empty;
    assign event_channel         = head_evt.channel[CH_W-1:0];
    assign event_class           = head_evt.cls;
    assign event_timestamp       = head_evt.timestamp[TS_W-1:0];
    assign fifo_overflow         = overflow_q;

endmodule

// File: tb/tb_spike_event_processor.sv
// Self-checking bench: a behavioural reference model fills an expected-event queue that a
// monitor compares against every FIFO pop; each scenario task also checks outputs inline.
`timescale 1ns/1ps
module tb_spike_event_processor;

    localparam int unsigned NCH   = 4;
    localparam int unsigned SW    = 8;
    localparam int unsigned TW    = 16;
    localparam int unsigned TSW   = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CHW   = 2;
    localparam int unsigned EW    = TSW + CHW + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [SW-1:0]     sample_in;
    logic              sample_valid;
    logic              frame_start;
    logic [SW-1:0]     class_a_thresh_in;
    logic [SW-1:0]     class_b_thresh_in;
    logic [TW-1:0]     timeout_period_in;
    logic [NCH-1:0]    spike_detection_array;
    logic [2*NCH-1:0]  event_out_array;
    logic              event_valid;
    logic              event_ready;
    logic [CHW-1:0]    event_channel;
    logic [1:0]        event_class;
    logic [TSW-1:0]    event_timestamp;
    logic              fifo_overflow;

    always #5 clk = ~clk;

    spike_event_processor #(
        .NUM_CHANNELS (NCH),
        .SAMPLE_W     (SW),
        .TIMEOUT_W    (TW),
        .TS_W         (TSW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .sample_in             (sample_in),
        .sample_valid          (sample_valid),
        .frame_start           (frame_start),
        .class_a_thresh_in     (class_a_thresh_in),
        .class_b_thresh_in     (class_b_thresh_in),
        .timeout_period_in     (timeout_period_in),
        .spike_detection_array (spike_detection_array),
        .event_out_array       (event_out_array),
        .event_valid           (event_valid),
        .event_ready           (event_ready),
        .event_channel         (event_channel),
        .event_class           (event_class),
        .event_timestamp       (event_timestamp),
        .fifo_overflow         (fifo_overflow)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] exp_head;

    int             m_prev [NCH];
    bit             m_pv   [NCH];
    int             m_refr [NCH];
    int             m_ch;
    logic [TSW-1:0] m_ts;
    logic [NCH-1:0]   m_det;
    logic [2*NCH-1:0] m_evt;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_prev[i] = 0;
            m_pv[i]   = 1'b0;
            m_refr[i] = 0;
        end
        m_ch  = 0;
        m_ts  = '0;
        m_det = '0;
        m_evt = '0;
        exp_q.delete();
    endfunction

    function automatic void model_step(int s, bit fs);
        int c, d, cls;
        c   = fs ? 0 : m_ch;
        d   = (s > m_prev[c]) ? s - m_prev[c] : m_prev[c] - s;
        cls = 0;
        if (!m_pv[c]) m_pv[c] = 1'b1;
        else if (m_refr[c] != 0) m_refr[c] = m_refr[c] - 1;
        else if (d >= int'(class_b_thresh_in)) cls = 2;
        else if (d >= int'(class_a_thresh_in)) cls = 1;
        if (cls != 0) begin
            m_refr[c] = int'(timeout_period_in);
            exp_q.push_back({m_ts, CHW'(c), 2'(cls)});
        end
        m_prev[c]        = s;
        m_det[c]         = (cls != 0);
        m_evt[2*c +: 2]  = 2'(cls);
        if (c == NCH - 1) m_ts = m_ts + 1'b1;
        m_ch = (c == NCH - 1) ? 0 : c + 1;
    endfunction

    // Scoreboard: every pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && event_valid && event_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL fifo_pop: got ts=%0d ch=%0d cls=%b, required no entry",
                         event_timestamp, event_channel, event_class);
            end else begin
                exp_head = exp_q.pop_front();
                if ({event_timestamp, event_channel, event_class} !== exp_head) begin
                    n_err++;
                    $display("FAIL fifo_pop: got ts=%0d ch=%0d cls=%b, required ts=%0d ch=%0d cls=%b",
                             event_timestamp, event_channel, event_class,
                             exp_head[EW-1 -: TSW], exp_head[3:2], exp_head[1:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(int s, bit fs);
        sample_in    = SW'(s);
        sample_valid = 1'b1;
        frame_start  = fs;
        model_step(s, fs);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic send_frame(int a, int b, int c, int d);
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, 1'b0);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        n_cmp++;
        if (exp_q.size() != 0 || event_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d entries outstanding, event_valid=%b, required 0 and 0",
                     name, exp_q.size(), event_valid);
        end
    endtask

    task automatic test_reset();
        event_ready = 1'b0;
        do_reset();
        send_frame(0, 0, 0, 0);
        send_frame(100, 100, 100, 100);
        idle(2);
        n_cmp++;
        if (event_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_valid: got %b required 1", event_valid);
        end
        send(0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({spike_detection_array, event_out_array, event_valid, event_channel, event_class,
             event_timestamp, fifo_overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got det=%b evt=%b v=%b ch=%0d cls=%b ts=%0d ovf=%b, required all 0",
                     spike_detection_array, event_out_array, event_valid, event_channel,
                     event_class, event_timestamp, fifo_overflow);
        end
        model_reset();
        rst_n       = 1'b1;
        event_ready = 1'b1;
        send_frame(100, 0, 0, 0);
        send(150, 1'b0);
        idle(1);
        n_cmp++;
        if (spike_detection_array !== 4'b0001 || event_out_array !== 8'b0000_0010) begin
            n_err++;
            $display("FAIL reset_first_ch0: got det=%b evt=%b, required 0001 00000010",
                     spike_detection_array, event_out_array);
        end
        wait_drain("reset");
    endtask

    task automatic test_class_a();
        do_reset();
        event_ready = 1'b0;
        send_frame(10, 0, 0, 0);
        send(35, 1'b0);
        n_cmp++;
        if (event_valid !== 1'b0) begin
            n_err++;
            $display("FAIL class_a_latency: got event_valid=%b one edge early, required 0", event_valid);
        end
        idle(1);
        n_cmp++;
        if (event_valid !== 1'b1 || spike_detection_array !== 4'b0001
            || event_out_array[1:0] !== 2'b01) begin
            n_err++;
            $display("FAIL class_a_flags: got v=%b det=%b evt=%b, required 1 0001 01",
                     event_valid, spike_detection_array, event_out_array[1:0]);
        end
        n_cmp++;
        if (event_timestamp !== 8'd1 || event_channel !== 2'd0 || event_class !== 2'b01) begin
            n_err++;
            $display("FAIL class_a_head: got ts=%0d ch=%0d cls=%b, required ts=1 ch=0 cls=01",
                     event_timestamp, event_channel, event_class);
        end
        send(0, 1'b0);
        send(0, 1'b0);
        send(0, 1'b0);
        event_ready = 1'b1;
        wait_drain("class_a");
    endtask

    task automatic test_class_b();
        do_reset();
        send_frame(0, 0, 200, 100);
        send_frame(0, 0, 150, 119);
        idle(1);
        n_cmp++;
        if (event_out_array !== 8'b0010_0000 || spike_detection_array !== 4'b0100) begin
            n_err++;
            $display("FAIL class_b_fall: got evt=%b det=%b, required 00100000 0100",
                     event_out_array, spike_detection_array);
        end
        send_frame(0, 0, 150, 139);
        idle(1);
        n_cmp++;
        if (event_out_array !== m_evt || event_out_array[7:6] !== 2'b01) begin
            n_err++;
            $display("FAIL class_a_boundary: got evt=%b, required %b", event_out_array, m_evt);
        end
        class_a_thresh_in = 8'd40;
        class_b_thresh_in = 8'd20;
        send_frame(30, 0, 150, 139);
        idle(1);
        n_cmp++;
        if (event_out_array[1:0] !== 2'b10 || spike_detection_array !== m_det) begin
            n_err++;
            $display("FAIL class_b_priority: got evt=%b det=%b, required evt[1:0]=10 det=%b",
                     event_out_array, spike_detection_array, m_det);
        end
        class_a_thresh_in = 8'd20;
        class_b_thresh_in = 8'd40;
        wait_drain("class_b");
    endtask

    task automatic test_refractory();
        int s_tab [5]    = '{0, 50, 110, 50, 110};
        int exp_tmo2 [5] = '{0, 2, 0, 0, 2};
        int exp_tmo0 [5] = '{0, 2, 2, 2, 2};
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            timeout_period_in = (pass == 0) ? 16'd2 : 16'd0;
            for (int k = 0; k < 5; k++) begin
                send_frame(0, s_tab[k], 0, 0);
                n_cmp++;
                if (event_out_array[3:2] !== 2'((pass == 0) ? exp_tmo2[k] : exp_tmo0[k])) begin
                    n_err++;
                    $display("FAIL refractory_t%0d_f%0d: got cls=%b, required %0d",
                             2 - 2 * pass, k, event_out_array[3:2],
                             (pass == 0) ? exp_tmo2[k] : exp_tmo0[k]);
                end
            end
            wait_drain("refractory");
        end
        timeout_period_in = 16'd2;
    endtask

    task automatic test_overflow();
        do_reset();
        timeout_period_in = 16'd0;
        event_ready       = 1'b0;
        send_frame(0, 0, 0, 0);
        send_frame(100, 100, 100, 100);
        send_frame(0, 0, 0, 0);
        idle(1);
        n_cmp++;
        if (fifo_overflow !== 1'b0 || event_valid !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_full: got ovf=%b v=%b with 8 stored, required 0 1",
                     fifo_overflow, event_valid);
        end
        send(100, 1'b0);
        // Ninth event meets a full FIFO and is lost.
        void'(exp_q.pop_back());
        idle(2);
        n_cmp++;
        if (fifo_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_set: got %b required 1", fifo_overflow);
        end
        event_ready = 1'b1;
        wait_drain("overflow");
        n_cmp++;
        if (fifo_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_sticky: got %b required 1", fifo_overflow);
        end
        timeout_period_in = 16'd2;
    endtask

    task automatic test_wrap_resync();
        do_reset();
        timeout_period_in = 16'd0;
        for (int f = 0; f < 255; f++) send_frame(0, 0, 0, 0);
        event_ready = 1'b0;
        send_frame(100, 0, 0, 0);
        send_frame(0, 0, 0, 0);
        idle(1);
        n_cmp++;
        if (event_valid !== 1'b1 || event_timestamp !== 8'hFF || event_class !== 2'b10) begin
            n_err++;
            $display("FAIL wrap_last_ts: got v=%b ts=%0h cls=%b, required 1 ff 10",
                     event_valid, event_timestamp, event_class);
        end
        event_ready = 1'b1;
        idle(1);
        event_ready = 1'b0;
        n_cmp++;
        if (event_timestamp !== 8'h00 || event_channel !== 2'd0 || event_class !== 2'b10) begin
            n_err++;
            $display("FAIL wrap_zero_ts: got ts=%0h ch=%0d cls=%b, required 00 0 10",
                     event_timestamp, event_channel, event_class);
        end
        event_ready = 1'b1;
        send(0, 1'b0);
        send(0, 1'b0);
        send(60, 1'b1);
        idle(1);
        n_cmp++;
        if (spike_detection_array !== 4'b0001 || event_out_array !== 8'b0000_0010) begin
            n_err++;
            $display("FAIL resync_ch0: got det=%b evt=%b, required 0001 00000010",
                     spike_detection_array, event_out_array);
        end
        send(0, 1'b0);
        send(0, 1'b0);
        send(0, 1'b0);
        send(60, 1'b0);
        wait_drain("resync");
        timeout_period_in = 16'd2;
    endtask

    initial begin
        rst_n             = 1'b0;
        sample_in         = '0;
        sample_valid      = 1'b0;
        frame_start       = 1'b0;
        class_a_thresh_in = 8'd20;
        class_b_thresh_in = 8'd40;
        timeout_period_in = 16'd2;
        event_ready       = 1'b1;
        model_reset();
        test_reset();
        test_class_a();
        test_class_b();
        test_refractory();
        test_overflow();
        test_wrap_resync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
